serv_dbus_reg: RTL and testbench
================================

Name: serv_dbus_reg

Overview:
- Registered Wishbone classic slice between the SERV core data bus (driven by the memory interface's dat/sel plus core address/we/cyc) and the external data bus.
- Breaks the combinational path from the external ack/rdt back into the core's load-data shift register.
- Holds request fields stable for the whole external transaction.
- Converts a hung external transfer into a timed-out ack, so the core never stalls forever.

Parameters:
- TIMEOUT, 255: max BUSY cycles without external ack before forced completion; 0 disables timeout.
- TIMEOUT_RDT, 32'h00000000: read data returned on a timed-out read.

Ports:
- i_clk  in  1  clock, rising-edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_wb_cpu_adr  in  32  core byte address
- i_wb_cpu_dat  in  32  core write data (already lane-shifted)
- i_wb_cpu_sel  in  4  core byte enables
- i_wb_cpu_we  in  1  core write strobe
- i_wb_cpu_cyc  in  1  core cycle request
- o_wb_cpu_rdt  out  32  registered read data to core
- o_wb_cpu_ack  out  1  single-cycle ack to core
- o_wb_mem_adr  out  32  registered address
- o_wb_mem_dat  out  32  registered write data
- o_wb_mem_sel  out  4  registered byte enables
- o_wb_mem_we  out  1  registered write strobe
- o_wb_mem_cyc  out  1  external cycle
- i_wb_mem_rdt  in  32  external read data
- i_wb_mem_ack  in  1  external ack
- o_timeout  out  1  one-cycle pulse when a transfer is force-completed

Behaviour:
- Reset (i_rst_n low, async): state=IDLE; all outputs 0; timeout counter 0. Released synchronously to i_clk.
- States: IDLE, BUSY, RESP; registered state, encoding from package.
- IDLE:
  - On i_wb_cpu_cyc=1: capture adr/dat/sel/we into o_wb_mem_*; clear counter; go to BUSY.
  - o_wb_mem_cyc rises on the same edge, so it is 1 throughout BUSY.
- BUSY:
  - o_wb_mem_cyc=1; counter increments every cycle.
  - If i_wb_mem_ack=1: o_wb_cpu_rdt <= we ? 0 : i_wb_mem_rdt; o_wb_mem_cyc <= 0; go to RESP.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: o_wb_cpu_rdt <= we ? 0 : TIMEOUT_RDT; o_wb_mem_cyc <= 0; o_timeout <= 1 for one cycle; go to RESP.
  - Else if i_wb_cpu_cyc=0 (core abort): o_wb_mem_cyc <= 0; go to IDLE; no cpu ack is issued.
  - Priority: ack > timeout > abort. An ack arriving in the timeout cycle is a normal completion with no o_timeout.
- RESP:
  - o_wb_cpu_ack=1 for exactly one cycle; o_wb_cpu_rdt valid the same cycle; go to IDLE.
  - o_wb_cpu_rdt holds its value until the next completion.
- Core contract: the core drops i_wb_cpu_cyc in the cycle after o_wb_cpu_ack. IDLE therefore sees cyc=0 and starts no spurious transfer.
- Back-to-back requests: a new cyc seen in IDLE is accepted in the first IDLE cycle.
- Latency:
  - cyc high at edge N; o_wb_mem_cyc high after N.
  - External ack at edge N+1 gives o_wb_cpu_ack high in cycle N+2 (2 cycles minimum).
  - Each external wait state adds 1 cycle.
- Request fields o_wb_mem_adr/dat/sel/we change only on IDLE→BUSY; otherwise held.
- i_wb_mem_ack outside BUSY is ignored.
- Counter width: $clog2(TIMEOUT+1), minimum 1. It never wraps because BUSY is left at TIMEOUT-1.
- Reset mid-transfer: all state cleared immediately. o_wb_mem_cyc drops asynchronously; no ack to the core.

Decomposition:
- Shared package serv_dbus_pkg: state localparams (IDLE=2'd0, BUSY=2'd1, RESP=2'd2) and a TIMEOUT counter-width function.
- One natural sub-module, serv_dbus_timeout:
  - Inputs: clear, enable.
  - Output: expire pulse at count TIMEOUT-1; tied to 0 when TIMEOUT==0.
- FSM and data registers live in serv_dbus_reg.

Test Plan:
- Read, zero wait: cyc=1, we=0, adr=0x100, sel=4'hF; external ack on first BUSY cycle with rdt=0xDEADBEEF -> o_wb_cpu_ack 2 cycles after cyc; rdt=0xDEADBEEF; o_wb_mem_cyc high exactly 1 cycle.
- Write, 3 wait states: we=1, dat=0x000000A5, sel=4'b0001 -> mem_adr/dat/sel stable for 4 BUSY cycles; cpu ack at cycle 5; rdt=0.
- Timeout: TIMEOUT=4, external never acks -> mem_cyc high 4 cycles; o_timeout and cpu ack both pulse once; rdt=TIMEOUT_RDT for a read, 0 for a write.
- Ack in timeout cycle: TIMEOUT=4, ack on 4th BUSY cycle with rdt=0x12345678 -> normal completion; o_timeout stays 0.
- Abort: core drops cyc on 2nd BUSY cycle -> mem_cyc low next edge; no cpu ack; the next request starts cleanly from IDLE.
- Reset mid-BUSY: assert i_rst_n=0 asynchronously -> all outputs 0 before the next clock edge; after release, a read completes normally.

Source files
------------

// File: rtl/serv_dbus_pkg.sv
// rtl/serv_dbus_pkg.sv - shared state encoding and counter sizing for the registered data-bus slice
package serv_dbus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // A timeout of 0 still needs a 1-bit counter so the logic stays well-formed.
  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/serv_dbus_timeout.sv
// rtl/serv_dbus_timeout.sv - busy-cycle counter that flags a hung external transfer
module serv_dbus_timeout
  import serv_dbus_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = cnt_width(TIMEOUT);
  localparam logic [W-1:0] LAST = (TIMEOUT == 0) ? '0 : W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + W'(1);
    end
  end

  // The owner leaves BUSY on expiry, so the counter never runs past LAST while enabled.
  assign expire = (TIMEOUT != 0) && enable && (cnt == LAST);

endmodule

// File: rtl/serv_dbus_reg.sv
// rtl/serv_dbus_reg.sv - registered Wishbone slice between the SERV data bus and external memory
module serv_dbus_reg
  import serv_dbus_pkg::*;
#(
  parameter int          TIMEOUT     = 255,
  parameter logic [31:0] TIMEOUT_RDT = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_wb_cpu_adr,
  input  logic [31:0] i_wb_cpu_dat,
  input  logic [3:0]  i_wb_cpu_sel,
  input  logic        i_wb_cpu_we,
  input  logic        i_wb_cpu_cyc,
  output logic [31:0] o_wb_cpu_rdt,
  output logic        o_wb_cpu_ack,
  output logic [31:0] o_wb_mem_adr,
  output logic [31:0] o_wb_mem_dat,
  output logic [3:0]  o_wb_mem_sel,
  output logic        o_wb_mem_we,
  output logic        o_wb_mem_cyc,
  input  logic [31:0] i_wb_mem_rdt,
  input  logic        i_wb_mem_ack,
  output logic        o_timeout
);

  state_t state;
  state_t state_nxt;
  logic   busy;
  logic   expire;
  logic   timeout_q;

  assign busy = (state == BUSY);

  serv_dbus_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .clear  (!busy),
    .enable (busy),
    .expire (expire)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // External ack beats timeout, timeout beats a core abort.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (i_wb_cpu_cyc) state_nxt = BUSY;
      BUSY: begin
        if (i_wb_mem_ack || expire) begin
          state_nxt = RESP;
        end else if (!i_wb_cpu_cyc) begin
          state_nxt = IDLE;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wb_mem_adr <= '0;
      o_wb_mem_dat <= '0;
      o_wb_mem_sel <= '0;
      o_wb_mem_we  <= 1'b0;
      o_wb_cpu_rdt <= '0;
      timeout_q    <= 1'b0;
    end else begin
      timeout_q <= busy && !i_wb_mem_ack && expire;
      if (state == IDLE && i_wb_cpu_cyc) begin
        o_wb_mem_adr <= i_wb_cpu_adr;
        o_wb_mem_dat <= i_wb_cpu_dat;
        o_wb_mem_sel <= i_wb_cpu_sel;
        o_wb_mem_we  <= i_wb_cpu_we;
      end
      if (busy) begin
        if (i_wb_mem_ack) begin
          o_wb_cpu_rdt <= o_wb_mem_we ? 32'h0 : i_wb_mem_rdt;
        end else if (expire) begin
          o_wb_cpu_rdt <= o_wb_mem_we ? 32'h0 : TIMEOUT_RDT;
        end
      end
    end
  end

  // Decoded straight from the state flops, so reset drops them without waiting for a clock.
  assign o_wb_mem_cyc = busy;
  assign o_wb_cpu_ack = (state == RESP);
  assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_serv_dbus_reg.sv
// tb/tb_serv_dbus_reg.sv - self-checking bench for serv_dbus_reg
module tb_serv_dbus_reg;

  localparam int          T    = 4;
  localparam logic [31:0] TRDT = 32'hBAD0_0BAD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cpu_adr, cpu_dat, cpu_rdt, mem_adr, mem_dat, mem_rdt;
  logic [3:0]  cpu_sel, mem_sel;
  logic        cpu_we, cpu_cyc, cpu_ack, mem_we, mem_cyc, mem_ack, tmo;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_rdt = 32'h0;

  serv_dbus_reg #(.TIMEOUT(T), .TIMEOUT_RDT(TRDT)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_wb_cpu_adr (cpu_adr),
    .i_wb_cpu_dat (cpu_dat),
    .i_wb_cpu_sel (cpu_sel),
    .i_wb_cpu_we  (cpu_we),
    .i_wb_cpu_cyc (cpu_cyc),
    .o_wb_cpu_rdt (cpu_rdt),
    .o_wb_cpu_ack (cpu_ack),
    .o_wb_mem_adr (mem_adr),
    .o_wb_mem_dat (mem_dat),
    .o_wb_mem_sel (mem_sel),
    .o_wb_mem_we  (mem_we),
    .o_wb_mem_cyc (mem_cyc),
    .i_wb_mem_rdt (mem_rdt),
    .i_wb_mem_ack (mem_ack),
    .o_timeout    (tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cyc"}, {31'h0, mem_cyc}, 32'h0);
    check({tag, "_ack"}, {31'h0, cpu_ack}, 32'h0);
    check({tag, "_tmo"}, {31'h0, tmo}, 32'h0);
    check({tag, "_adr"}, mem_adr, 32'h0);
    check({tag, "_dat"}, mem_dat, 32'h0);
    check({tag, "_selwe"}, {27'h0, mem_sel, mem_we}, 32'h0);
    check({tag, "_rdt"}, cpu_rdt, 32'h0);
  endtask

  // ack_at / abort_at: BUSY cycle (1-based) in which the slave acks / the core drops cyc; 0 = never.
  task automatic run_txn(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic we, input int ack_at,
                         input int abort_at, input logic [31:0] ext_rdt);
    int          e_ack, e_ab, kind, end_c;
    int          n_cyc, n_ack, n_to, ack_cyc, to_cyc;
    bit          fields_ok;
    logic [31:0] exp_rdt, rdt_at_ack;
    e_ack = (ack_at > 0) ? ack_at : 1000;
    e_ab  = (abort_at > 0) ? abort_at : 1000;
    if (e_ack <= T && e_ack <= e_ab) begin
      kind = 0; end_c = e_ack;
    end else if (T <= e_ab) begin
      kind = 1; end_c = T;
    end else begin
      kind = 2; end_c = e_ab;
    end
    exp_rdt = (kind == 0) ? (we ? 32'h0 : ext_rdt) :
              (kind == 1) ? (we ? 32'h0 : TRDT) : last_rdt;
    n_cyc = 0; n_ack = 0; n_to = 0; ack_cyc = 0; to_cyc = 0;
    fields_ok = 1'b1; rdt_at_ack = 32'hx;

    @(negedge clk);
    cpu_adr = adr; cpu_dat = dat; cpu_sel = sel; cpu_we = we; cpu_cyc = 1'b1;
    mem_ack = 1'b0; mem_rdt = $urandom;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_cyc) begin
        n_cyc++;
        if (mem_adr !== adr || mem_dat !== dat || mem_sel !== sel || mem_we !== we)
          fields_ok = 1'b0;
      end
      if (cpu_ack) begin
        n_ack++;
        if (ack_cyc == 0) ack_cyc = c;
        rdt_at_ack = cpu_rdt;
      end
      if (tmo) begin
        n_to++;
        to_cyc = c;
      end
      cpu_adr = $urandom; cpu_dat = $urandom; cpu_sel = 4'($urandom); cpu_we = 1'($urandom);
      mem_ack = (c == ack_at);
      mem_rdt = (c == ack_at) ? ext_rdt : $urandom;
      if (cpu_ack || c == abort_at) cpu_cyc = 1'b0;
    end
    mem_ack = 1'b0;

    check({tag, "_memcyc_len"}, n_cyc, end_c);
    check({tag, "_ack_count"}, n_ack, (kind != 2) ? 1 : 0);
    check({tag, "_tmo_count"}, n_to, (kind == 1) ? 1 : 0);
    check({tag, "_fields_stable"}, {31'h0, fields_ok}, 32'h1);
    if (kind != 2) begin
      check({tag, "_ack_cycle"}, ack_cyc, end_c + 1);
      check({tag, "_rdt_at_ack"}, rdt_at_ack, exp_rdt);
    end
    if (kind == 1) check({tag, "_tmo_cycle"}, to_cyc, end_c + 1);
    check({tag, "_rdt_held"}, cpu_rdt, exp_rdt);
    check({tag, "_adr_held"}, mem_adr, adr);
    last_rdt = exp_rdt;
  endtask

  initial begin
    rst_n = 1'b0; cpu_adr = '0; cpu_dat = '0; cpu_sel = '0; cpu_we = 1'b0; cpu_cyc = 1'b0;
    mem_rdt = '0; mem_ack = 1'b0;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_txn("rd_zero_wait", 32'h100, 32'h0, 4'hF, 1'b0, 1, 0, 32'hDEAD_BEEF);
    run_txn("wr_3wait", 32'h200, 32'h0000_00A5, 4'b0001, 1'b1, 4, 0, 32'hFFFF_FFFF);
    run_txn("rd_timeout", 32'h300, 32'h0, 4'hF, 1'b0, 0, 0, 32'h0);
    run_txn("wr_timeout", 32'h304, 32'h1234, 4'h3, 1'b1, 0, 0, 32'h0);
    run_txn("rd_ack_at_tmo", 32'h308, 32'h0, 4'hF, 1'b0, T, 0, 32'h1234_5678);
    run_txn("rd_late_ack", 32'h30C, 32'h0, 4'hF, 1'b0, T + 1, 0, 32'h5555_AAAA);
    run_txn("abort", 32'h400, 32'h0, 4'hF, 1'b0, 0, 2, 32'h0);
    run_txn("after_abort", 32'h404, 32'h0, 4'hC, 1'b0, 2, 0, 32'hCAFE_F00D);
    run_txn("ack_vs_abort", 32'h408, 32'h0, 4'hF, 1'b0, 2, 2, 32'h0BAD_CAFE);

    // Stray slave acks while idle must not reach the core.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ack = 1'b1; mem_rdt = $urandom;
      check("idle_ack_ignored", {30'h0, cpu_ack, mem_cyc}, 32'h0);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    check("idle_ack_no_resp", {30'h0, cpu_ack, tmo}, 32'h0);
    check("idle_rdt_held", cpu_rdt, last_rdt);

    // Asynchronous reset in the middle of a transfer.
    @(negedge clk);
    cpu_adr = 32'h500; cpu_dat = 32'h0; cpu_sel = 4'hF; cpu_we = 1'b0; cpu_cyc = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", {31'h0, mem_cyc}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    cpu_cyc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_rdt = 32'h0;
    run_txn("rd_after_rst", 32'h504, 32'h0, 4'hF, 1'b0, 2, 0, 32'h7777_1111);

    for (int n = 0; n < 24; n++) begin
      run_txn("rand", $urandom, $urandom, 4'($urandom), 1'($urandom),
              int'($urandom_range(0, 6)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0,
              $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
